copy_engine: RTL
================

COPY_ENGINE -- requirements
Module: copy_engine

Interface
REQ-001 SHALL have parameter HIST_SIZE, default 4096, history window depth in bytes (power of two).
REQ-002 SHALL have localparam ADDR_WIDTH = $clog2(HIST_SIZE).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port lit_in, input, 8, literal byte.
REQ-006 SHALL have port lit_valid_in, input, 1, literal present.
REQ-007 SHALL have port cpy_offset_in, input, ADDR_WIDTH, copy distance back from next write position.
REQ-008 SHALL have port cpy_len_in, input, 4, copy length code; bytes = code + 3, giving 3..18.
REQ-009 SHALL have port cpy_valid_in, input, 1, copy command present.
REQ-010 SHALL have port cmd_ready_out, output, 1, command accepted this cycle when high.
REQ-011 SHALL have port data_out, output, 8, decompressed byte.
REQ-012 SHALL have port data_valid_out, output, 1, data_out valid.
REQ-013 SHALL have port data_ready_in, input, 1, downstream accepts data_out.
REQ-014 SHALL have port error_out, output, 1, sticky bad-offset flag.

Function
REQ-015 SHALL hold history in a circular buffer: HIST_SIZE x 8 bits, write pointer wr_ptr (ADDR_WIDTH bits), fill counter saturating at HIST_SIZE.
REQ-016 SHALL implement states IDLE and COPY.
REQ-017 IDLE: cmd_ready_out = 1 iff output slot empty or (data_valid_out and data_ready_in).
REQ-018 Literal handshake (IDLE, lit_valid_in, cmd_ready_out): write lit_in at wr_ptr, wr_ptr++, data_out = lit_in, data_valid_out = 1 next cycle; latency 1.
REQ-019 Copy handshake (IDLE, cpy_valid_in, cmd_ready_out): latch rd_ptr = wr_ptr - cpy_offset_in (mod HIST_SIZE), remaining = cpy_len_in + 3, move to COPY; no byte emitted that cycle.
REQ-020 lit_valid_in and cpy_valid_in both high SHALL accept the copy; the literal is dropped.
REQ-021 COPY: each cycle the output slot is free or draining, read buf[rd_ptr], write it at wr_ptr, present it on data_out; rd_ptr++, wr_ptr++, remaining--; one byte per cycle.
REQ-022 COPY with slot full and data_ready_in low SHALL hold all pointers and data_out stable.
REQ-023 Read SHALL see a byte written the previous cycle, so offset < length (incl. offset 1 run-length) replicates correctly.
REQ-024 COPY SHALL return to IDLE in the cycle the last byte is emitted; cmd_ready_out = 0 throughout COPY.
REQ-025 Pointers SHALL wrap modulo HIST_SIZE without gaps.
REQ-026 data_valid_out SHALL drop after a handshake when no new byte is produced that cycle.

Reset
REQ-027 Reset SHALL force IDLE, wr_ptr = 0, rd_ptr = 0, fill = 0, remaining = 0, data_out = 0x00, data_valid_out = 0, error_out = 0.
REQ-028 Reset mid-COPY SHALL abort immediately; no further bytes are emitted. Buffer contents are not cleared.

Configuration
REQ-029 Macro COPY_OFFSET_CHECK_EN defined: a copy with cpy_offset_in = 0 or cpy_offset_in > fill SHALL set error_out (sticky until reset) and emit 0x00 for each of its bytes, still writing them to history.
REQ-030 Macro COPY_OFFSET_CHECK_EN undefined: no check; error_out tied 0; out-of-range copies emit whatever the buffer holds.

Verification
REQ-031 Reset; literals 0x41,0x42,0x43 with data_ready_in = 1 -> data_out 0x41,0x42,0x43 on cycles 1,2,3 after each accept.
REQ-032 After 0x41,0x42,0x43: copy offset 3, code 3 (6 bytes) -> 0x41,0x42,0x43,0x41,0x42,0x43; cmd_ready_out low for 6 cycles.
REQ-033 After literal 0x5A: copy offset 1, code 15 (18 bytes) -> eighteen 0x5A.
REQ-034 Mid-copy, hold data_ready_in low 4 cycles -> data_out and data_valid_out stable; sequence resumes with no byte lost or repeated.
REQ-035 Write 4095 literals (byte = index mod 256), then copy offset 4095, code 0 -> wr_ptr wraps through 0; output 0x00,0x01,0x02.
REQ-036 With COPY_OFFSET_CHECK_EN, after 2 literals: copy offset 5 -> error_out = 1, three 0x00 bytes; reset clears error_out.

Source files
------------

// File: rtl/copy_engine.sv
// copy_engine: LZ-style literal/copy decoder over a circular history buffer.
// Optional macro COPY_OFFSET_CHECK_EN flags and zeroes copies with out-of-range offsets.
module copy_engine #(
  parameter int HIST_SIZE = 4096,
  localparam int ADDR_WIDTH = $clog2(HIST_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            lit_in,
  input  logic                  lit_valid_in,
  input  logic [ADDR_WIDTH-1:0] cpy_offset_in,
  input  logic [3:0]            cpy_len_in,
  input  logic                  cpy_valid_in,
  output logic                  cmd_ready_out,
  output logic [7:0]            data_out,
  output logic                  data_valid_out,
  input  logic                  data_ready_in,
  output logic                  error_out
);
  typedef enum logic {IDLE, COPY} state_t;
  state_t state;
  logic [7:0] mem [HIST_SIZE];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] fill;
  logic [4:0] remaining;
  logic slot_free, lit_acc, cpy_acc, emit, we;
  logic [7:0] cpy_byte, wr_byte;
  assign slot_free = !data_valid_out || data_ready_in;
  assign cmd_ready_out = state == IDLE && slot_free;
  assign cpy_acc = cmd_ready_out && cpy_valid_in;
  assign lit_acc = cmd_ready_out && lit_valid_in && !cpy_valid_in;
  assign emit = state == COPY && slot_free;
  assign we = lit_acc || emit;
  assign wr_byte = emit ? cpy_byte : lit_in;
`ifdef COPY_OFFSET_CHECK_EN
  logic bad, bad_cpy;
  assign bad = cpy_offset_in == '0 || {1'b0, cpy_offset_in} > fill;
  assign cpy_byte = bad_cpy ? 8'h00 : mem[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bad_cpy <= 1'b0;
      error_out <= 1'b0;
    end else if (cpy_acc) begin
      bad_cpy <= bad;
      error_out <= error_out | bad;
    end
`else
  assign cpy_byte = mem[rd_ptr];
  assign error_out = 1'b0;
`endif
  // Async read sees last cycle's write, so overlapping copies replicate.
  always_ff @(posedge clk)
    if (we) mem[wr_ptr] <= wr_byte;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
      remaining <= '0;
      data_out <= 8'h00;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= we || (data_valid_out && !data_ready_in);
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        data_out <= wr_byte;
        if (!fill[ADDR_WIDTH]) fill <= fill + 1'b1;
      end
      if (cpy_acc) begin
        rd_ptr <= wr_ptr - cpy_offset_in;
        remaining <= {1'b0, cpy_len_in} + 5'd3;
        state <= COPY;
      end
      if (emit) begin
        rd_ptr <= rd_ptr + 1'b1;
        remaining <= remaining - 5'd1;
        if (remaining == 5'd1) state <= IDLE;
      end
    end
endmodule
